// File: rtl/mux_pkg.sv
// mux_pkg: shared width helpers for the stream mux / arbiter family.
//   clog2_fn  : ceiling log2 of a positive integer (clog2_fn(1) == 0)
//   sel_w_fn  : width of a channel index, never narrower than 1 bit
package mux_pkg;

  function automatic int clog2_fn(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int sel_w_fn(input int n);
    return (n <= 1) ? 1 : clog2_fn(n);
  endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin picker.
// Scans req starting at ptr and wrapping modulo NUM_IN; the first requester
// found wins. Works for any NUM_IN, never produces an index >= NUM_IN.
// Ports:
//   req       in  NUM_IN  request vector
//   ptr       in  SEL_W   highest-priority index (expected < NUM_IN)
//   grant     out NUM_IN  one-hot grant, zero when no request
//   grant_idx out SEL_W   binary index of the granted requester
//   any       out 1       at least one request present
module rr_grant #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);

  int idx;

  // Walk from the farthest candidate back toward ptr so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = |req;
    idx       = 0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: NUM_IN-channel, DATA_W-bit valid/ready stream multiplexer
// with round-robin arbitration and a registered output stage.
// Optional packet lock: define RR_STREAM_MUX_PKT_LOCK_EN to add in_last /
// out_last and keep a channel granted until the beat carrying last.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   in_valid     per-channel beat valid
//   in_data      flattened channel data, channel i at [i*DATA_W +: DATA_W]
//   in_ready     per-channel accept strobe, one-hot or zero
//   in_last      (lock build only) per-channel end-of-packet marker
//   out_valid    registered beat valid
//   out_data     registered beat data
//   out_sel      index of the channel that supplied out_data
//   out_last     (lock build only) registered end-of-packet marker
//   out_ready    downstream accept
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  parameter  int DATA_W = 32,
  localparam int SEL_W  = sel_w_fn(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  input  logic [NUM_IN-1:0]        in_last,
  output logic                     out_last,
`endif
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  ptr_q;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              any;
  logic              load;
  logic [SEL_W-1:0]  ptr_next;
  logic [DATA_W-1:0] sel_data;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [SEL_W-1:0]  sel_p1;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic              lock_q;
  logic [SEL_W-1:0]  lock_ch_q;
  logic              last_p1;
`endif

  // While a packet is in flight only the locked channel may request, so
  // the picker can only return lock_ch regardless of ptr.
  always_comb begin
    req = in_valid;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (SEL_W'(i) != lock_ch_q) req[i] = 1'b0;
      end
    end
`endif
  end

  rr_grant #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_grant (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // The output slot is free when empty or being drained this cycle.
  assign load     = any && (!vld_p1 || out_ready) && !reset;
  assign in_ready = load ? grant : '0;
  assign ptr_next = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) sel_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  // ---- stage p1: registered output beat ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr_q   <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      last_p1   <= 1'b0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
`endif
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      sel_p1  <= grant_idx;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      last_p1 <= |(in_last & grant);
      if (|(in_last & grant)) begin
        lock_q <= 1'b0;
        ptr_q  <= ptr_next;
      end else begin
        lock_q    <= 1'b1;
        lock_ch_q <= grant_idx;
      end
`else
      ptr_q <= ptr_next;
`endif
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  assign out_last  = last_p1;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  in_valid;
  logic [127:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_ready3;

  exp_t q4[$];
  exp_t q3[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_IN(4), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_stream_mux #(.NUM_IN(3), .DATA_W(8)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_ready (out_ready3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock, then settle just after the active edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pop4(input string tag);
    exp_t e;
    chk({tag, "_q_nonempty"}, 64'(q4.size() != 0), 64'd1);
    if (q4.size() != 0) begin
      e = q4.pop_front();
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_sel"},   64'(out_sel),   64'(e.sel));
      chk({tag, "_data"},  64'(out_data),  64'(e.data));
    end
  endtask

  task automatic pop3(input string tag);
    exp_t e;
    chk({tag, "_q_nonempty"}, 64'(q3.size() != 0), 64'd1);
    if (q3.size() != 0) begin
      e = q3.pop_front();
      chk({tag, "_valid"}, 64'(out_valid3), 64'd1);
      chk({tag, "_sel"},   64'(out_sel3),   64'(e.sel));
      chk({tag, "_data"},  64'(out_data3),  64'(e.data[7:0]));
    end
  endtask

  function automatic exp_t mk(input logic [1:0] s, input logic [31:0] d);
    exp_t e;
    e.sel  = s;
    e.data = d;
    return e;
  endfunction

  initial begin
    logic [3:0] rot_rdy [5];
    logic [1:0] rot_sel [5];
    logic [2:0] r3_rdy  [5];
    logic [1:0] r3_sel  [5];
    rot_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    r3_rdy  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    r3_sel  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    // Reset held two cycles with all channels valid
    reset      = 1'b1;
    in_valid   = 4'b1111;
    in_data    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    out_ready  = 1'b1;
    in_valid3  = 3'b000;
    in_data3   = {8'hC2, 8'hC1, 8'hC0};
    out_ready3 = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("reset_in_ready_c1", 64'(in_ready), 64'd0);
    cycle();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data",  64'(out_data),  64'd0);
    chk("reset_out_sel",   64'(out_sel),   64'd0);
    chk("reset3_out_valid", 64'(out_valid3), 64'd0);

    // Rotation with all channels valid and continuous out_ready
    reset = 1'b0;
    q4.push_back(mk(2'd0, 32'hA0));
    q4.push_back(mk(2'd1, 32'hA1));
    q4.push_back(mk(2'd2, 32'hA2));
    q4.push_back(mk(2'd3, 32'hA3));
    q4.push_back(mk(2'd0, 32'hA0));
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rot_in_ready_%0d", i), 64'(in_ready), 64'(rot_rdy[i]));
      chk($sformatf("rot_sel_model_%0d", i), 64'(q4[0].sel), 64'(rot_sel[i]));
      cycle();
      pop4($sformatf("rot_%0d", i));
    end

    // Output-only transfer: valid drops, data and sel hold
    in_valid = 4'b0000;
    #1;
    chk("drain_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_out_data",  64'(out_data),  64'hA0);
    chk("drain_out_sel",   64'(out_sel),   64'd0);

    // Backpressure: ptr is now 1, only channel 2 valid
    in_valid  = 4'b0100;
    in_data   = {32'h0, 32'h55, 32'h0, 32'h0};
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_load", 64'(in_ready), 64'b0100);
    q4.push_back(mk(2'd2, 32'h55));
    cycle();
    pop4("bp_first");
    in_data = {32'h0, 32'h66, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_stall_in_ready_%0d", i), 64'(in_ready), 64'd0);
      cycle();
      chk($sformatf("bp_stall_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_stall_data_%0d", i),  64'(out_data),  64'h55);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'b0100);
    q4.push_back(mk(2'd2, 32'h66));
    cycle();
    pop4("bp_next");
    in_valid = 4'b0000;
    cycle();
    chk("bp_drain_valid", 64'(out_valid), 64'd0);

    // Sparse wrap: ptr is 3, channels 0 and 1 valid
    in_data  = {32'h13, 32'h12, 32'h11, 32'h10};
    in_valid = 4'b0011;
    #1;
    chk("wrap_in_ready_0", 64'(in_ready), 64'b0001);
    q4.push_back(mk(2'd0, 32'h10));
    q4.push_back(mk(2'd1, 32'h11));
    cycle();
    pop4("wrap_0");
    chk("wrap_in_ready_1", 64'(in_ready), 64'b0010);
    cycle();
    pop4("wrap_1");
    // ptr must now be 2
    in_valid = 4'b1111;
    #1;
    chk("wrap_ptr2_in_ready", 64'(in_ready), 64'b0100);
    q4.push_back(mk(2'd2, 32'h12));
    cycle();
    pop4("wrap_2");

    // Reset mid-transfer: load channel 3 into a stalled output, then reset
    out_ready = 1'b0;
    #1;
    chk("mid_stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("mid_ptr3_in_ready", 64'(in_ready), 64'b1000);
    q4.push_back(mk(2'd3, 32'h13));
    cycle();
    pop4("mid_load");
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    chk("mid_reset_in_ready", 64'(in_ready), 64'd0);
    cycle();
    chk("mid_reset_valid", 64'(out_valid), 64'd0);
    chk("mid_reset_data",  64'(out_data),  64'd0);
    chk("mid_reset_sel",   64'(out_sel),   64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_reset_ptr0", 64'(in_ready), 64'b0001);
    q4.push_back(mk(2'd0, 32'h10));
    cycle();
    pop4("post_reset");
    in_valid = 4'b0000;
    cycle();
    chk("post_reset_drain", 64'(out_valid), 64'd0);

    // Non-power-of-two: NUM_IN=3 rotation never reaches index 3
    in_valid3 = 3'b111;
    q3.push_back(mk(2'd0, 32'hC0));
    q3.push_back(mk(2'd1, 32'hC1));
    q3.push_back(mk(2'd2, 32'hC2));
    q3.push_back(mk(2'd0, 32'hC0));
    q3.push_back(mk(2'd1, 32'hC1));
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("n3_in_ready_%0d", i), 64'(in_ready3), 64'(r3_rdy[i]));
      chk($sformatf("n3_sel_model_%0d", i), 64'(q3[0].sel), 64'(r3_sel[i]));
      cycle();
      pop3($sformatf("n3_%0d", i));
    end
    in_valid3 = 3'b000;
    cycle();
    chk("n3_drain_valid", 64'(out_valid3), 64'd0);

    chk("q4_empty", 64'(q4.size()), 64'd0);
    chk("q3_empty", 64'(q3.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, W-bit streaming multiplexer with round-robin arbitration and a registered output stage.
- Next generation of the team's 2/3/4:1 bit-sliced muxes.
- Selection is decided internally by fair arbitration, not an external select.
- Valid/ready handshakes sit on every port.
- Sits between multiple producer units (e.g. register-file read ports, ALU result sources) and a single shared consumer.

Parameters:
- NUM_IN, 4, number of input channels (>=1, any integer, not only powers of two)
- DATA_W, 32, data width per channel in bits (>=1)
- SEL_W, derived local constant = max(1, clog2(NUM_IN)), width of channel index

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  NUM_IN  per-channel beat valid
- in_data  input  NUM_IN*DATA_W  flattened channel data; channel i occupies bits [i*DATA_W +: DATA_W]
- in_ready  output  NUM_IN  per-channel accept strobe; one-hot or zero
- out_valid  output  1  registered output beat valid
- out_data  output  DATA_W  registered output data
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  downstream accept

Behaviour:
- Reset:
  - Synchronous, active-high, one clock clk.
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - in_ready=0 while reset is high.
  - Reset mid-transfer discards any held beat; no beat is accepted in a reset cycle.
- Transfer rules:
  - Input transfer on channel i occurs when in_valid[i] && in_ready[i] at a clock edge.
  - Output transfer occurs when out_valid && out_ready.
- Load condition: load = (|in_valid) && (!out_valid || out_ready). in_ready is combinational from in_valid, out_valid and out_ready.
- Grant:
  - g = first index j in ptr, ptr+1, ... NUM_IN-1, 0, ... ptr-1 with in_valid[j]=1.
  - Wrap is modulo NUM_IN; non-power-of-two NUM_IN must never select an index >= NUM_IN.
- in_ready[i] = load && (g==i). At most one bit is set.
- On load:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= (g==NUM_IN-1) ? 0 : g+1.
- Output-only transfer (out_valid && out_ready && !(|in_valid)): out_valid <= 0; out_data and out_sel hold.
- Stall (out_valid && !out_ready): all outputs and ptr hold; in_ready=0.
- Latency and throughput: one cycle from accept to out_valid; full throughput of one beat per clock under continuous out_ready.
- Fairness: with all channels continuously valid, grants rotate 0,1,...,NUM_IN-1,0. No channel waits more than NUM_IN-1 grants.
- NUM_IN=1: ptr is constant 0, out_sel=0, and the block behaves as a one-deep pipeline register.

Optional Feature:
- Macro: RR_STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, NUM_IN) and out_last (output, 1, reset 0, registered alongside out_data).
  - A granted beat with in_last[g]=0 sets lock<=1 and lock_ch<=g.
  - While locked, the grant is forced to lock_ch. Other channels get in_ready=0 even when lock_ch is idle.
  - ptr does not advance until the beat carrying last; that beat clears lock and sets ptr to lock_ch+1 mod NUM_IN.
  - Reset clears lock.
- Undefined: in_last and out_last do not exist; arbitration is per beat as above.

Decomposition:
- Shared package mux_pkg: clog2-based width function, and a SEL_W helper that clamps to a minimum of 1.
- One natural sub-module, rr_grant: combinational round-robin picker.
  - Inputs: req[NUM_IN], ptr[SEL_W].
  - Outputs: grant one-hot, grant index, any.
  - Reused by future arbiters.
- Output register, ptr and lock state stay in rr_stream_mux.

Test Plan:
- Reset then idle: hold reset 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
- Rotation: NUM_IN=4, all valid, data = channel index + 0xA0, out_ready=1 -> out_sel sequence 0,1,2,3,0; out_data A0,A1,A2,A3,A0, one per cycle after a 1-cycle latency.
- Backpressure: single valid channel 2 (0x55), out_ready=0 for 3 cycles -> out_valid=1, out_data=0x55 held, in_ready=0 during the stall; on out_ready=1, the next beat loads in the same cycle.
- Sparse wrap: ptr=3, in_valid=4'b0011 -> grant 0, then 1; ptr becomes 1, then 2.
- Non-power-of-two: NUM_IN=3, all valid -> out_sel 0,1,2,0, never 3.
- Lock (macro on): channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is valid -> out_sel=1,1,1 then 0; out_last high only on the third beat.
